// File: rtl/mat_res_serializer.sv
// Ping-pong drain stage for the matrix-multiply unit: captures whole N x N result
// matrices and streams them out one row per valid/ready beat, in capture order.
module mat_res_serializer #(
    parameter int W_OUT = 32,
    parameter int N     = 8,
    localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              cen,
    input  logic                              valid_in,
    input  logic [N-1:0][N-1:0][W_OUT-1:0]    result_in,
    output logic                              in_ready,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [N*W_OUT-1:0]                m_data,
    output logic [RW-1:0]                     m_row_idx,
    output logic                              m_last,
    output logic                              overflow
);

    logic [N-1:0][N-1:0][W_OUT-1:0] mbuf_q [2];
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic          ovf_q, ovf_d;

    logic cap_ok, ovf_hit, xfer, row_last;

    // Admission looks only at registered occupancy, so a buffer freed on this
    // edge cannot accept a capture until the next one.
    assign cap_ok   = cen & valid_in & ~full_q[wr_sel_q];
    assign ovf_hit  = cen & valid_in &  full_q[wr_sel_q];
    assign row_last = (row_cnt_q == RW'(N - 1));
    assign xfer     = m_valid & m_ready;

    assign in_ready  = ~full_q[wr_sel_q];
    assign m_valid   = cen & full_q[rd_sel_q];
    assign m_data    = m_valid ? mbuf_q[rd_sel_q][row_cnt_q] : '0;
    assign m_last    = m_valid & row_last;
    assign m_row_idx = row_cnt_q;
    assign overflow  = ovf_q;

    always_comb begin
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        row_cnt_d = row_cnt_q;
        ovf_d     = ovf_q;
        if (cap_ok) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (ovf_hit)
            ovf_d = 1'b1;
        // Capture and release always target different buffers, so both may apply.
        if (xfer) begin
            if (row_last) begin
                row_cnt_d        = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                row_cnt_d = row_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            row_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            row_cnt_q <= row_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && cap_ok)
            mbuf_q[wr_sel_q] <= result_in;
    end

endmodule

// File: tb/tb_mat_res_serializer.sv
// Directed bench for mat_res_serializer: one task per scenario, inline checks.
module tb_mat_res_serializer;

    localparam int W = 32;
    localparam int N = 8;
    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

    logic          clk = 1'b0;
    logic          rstn, cen, valid_in, m_ready;
    mat_t          result_in;
    logic          in_ready, m_valid, m_last, overflow;
    logic [N*W-1:0] m_data;
    logic [2:0]    m_row_idx;

    int tests = 0;
    int fails = 0;

    mat_res_serializer #(.W_OUT(W), .N(N)) dut (
        .clk(clk), .rstn(rstn), .cen(cen), .valid_in(valid_in),
        .result_in(result_in), .in_ready(in_ready), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_row_idx(m_row_idx),
        .m_last(m_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t mk_rc();
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = W'(r * 16 + c);
        return m;
    endfunction

    function automatic mat_t fill(input logic [W-1:0] v);
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = v;
        return m;
    endfunction

    function automatic logic [N*W-1:0] rc_row(input int r);
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++)
            v[c*W +: W] = W'(r * 16 + c);
        return v;
    endfunction

    function automatic logic [N*W-1:0] fill_row(input logic [W-1:0] x);
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++)
            v[c*W +: W] = x;
        return v;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; cen = 1'b1; valid_in = 1'b0; m_ready = 1'b0; result_in = '0;
        tick(); tick();
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        tests++; if (m_data !== '0) begin fails++; $display("FAIL reset_m_data got %h want 0", m_data); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_m_last got %b want 0", m_last); end
        tests++; if (m_row_idx !== 3'd0) begin fails++; $display("FAIL reset_row_idx got %0d want 0", m_row_idx); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        m_ready = 1'b1; result_in = mk_rc(); valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int r = 0; r < N; r++) begin
            tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL single_valid beat %0d got %b want 1", r, m_valid); end
            tests++; if (m_row_idx !== 3'(r)) begin fails++; $display("FAIL single_idx got %0d want %0d", m_row_idx, r); end
            tests++; if (m_data !== rc_row(r)) begin fails++; $display("FAIL single_data row %0d got %h want %h", r, m_data, rc_row(r)); end
            tests++; if (m_last !== (r == N-1)) begin fails++; $display("FAIL single_last row %0d got %b want %b", r, m_last, r == N-1); end
            tick();
        end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL single_end_valid got %b want 0", m_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_end_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int got = 0;
        int k = 0;
        m_ready = 1'b0; result_in = mk_rc(); valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        while (got < N && k < 100) begin
            m_ready = pat[k % 4];
            #1;
            tests++; if (m_valid !== 1'b1 || m_row_idx !== 3'(got) || m_data !== rc_row(got)) begin
                fails++; $display("FAIL bp_beat cycle %0d got v=%b idx=%0d want v=1 idx=%0d", k, m_valid, m_row_idx, got);
            end
            if (m_ready && m_valid) got++;
            k++;
            tick();
        end
        tests++; if (got !== N) begin fails++; $display("FAIL bp_count got %0d want %0d", got, N); end
        m_ready = 1'b0; #1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL bp_end_valid got %b want 0", m_valid); end
    endtask

    task automatic test_pingpong();
        mat_t a = fill(32'hFFFF_FFFF);
        mat_t b = fill(32'h7FFF_FFFF);
        m_ready = 1'b1; result_in = a; valid_in = 1'b1;
        tick();
        for (int k = 0; k < 2*N; k++) begin
            valid_in = (k == 1);
            if (k == 1) result_in = b;
            #1;
            tests++; if (m_valid !== 1'b1 || m_row_idx !== 3'(k % N) ||
                         m_data !== ((k < N) ? fill_row(32'hFFFF_FFFF) : fill_row(32'h7FFF_FFFF))) begin
                fails++; $display("FAIL pp_beat %0d got v=%b idx=%0d data=%h", k, m_valid, m_row_idx, m_data);
            end
            tick();
        end
        valid_in = 1'b0;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL pp_end_valid got %b want 0", m_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pp_overflow got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        result_in = fill(32'h0000_0001); valid_in = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ovf_in_ready_a got %b want 1", in_ready); end
        result_in = fill(32'h0000_0002);
        tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ovf_in_ready_b got %b want 0", in_ready); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", overflow); end
        result_in = fill(32'h0000_0003);
        tick();
        valid_in = 1'b0;
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        m_ready = 1'b1;
        for (int k = 0; k < 2*N; k++) begin
            #1;
            tests++; if (m_valid !== 1'b1 || m_row_idx !== 3'(k % N) ||
                         m_data !== fill_row((k < N) ? 32'h1 : 32'h2)) begin
                fails++; $display("FAIL ovf_drain beat %0d got v=%b idx=%0d data=%h", k, m_valid, m_row_idx, m_data);
            end
            tick();
        end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL ovf_c_emitted got %b want 0", m_valid); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_cen();
        do_reset();
        m_ready = 1'b1; result_in = mk_rc(); valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick(); tick(); tick();
        result_in = fill(32'hDEAD_BEEF);
        cen = 1'b0;
        for (int g = 0; g < 5; g++) begin
            valid_in = (g == 2);
            #1;
            tests++; if (m_valid !== 1'b0 || m_row_idx !== 3'd3) begin
                fails++; $display("FAIL cen_gap cycle %0d got v=%b idx=%0d want v=0 idx=3", g, m_valid, m_row_idx);
            end
            tick();
        end
        valid_in = 1'b0; cen = 1'b1;
        for (int r = 3; r < N; r++) begin
            #1;
            tests++; if (m_valid !== 1'b1 || m_row_idx !== 3'(r) || m_data !== rc_row(r)) begin
                fails++; $display("FAIL cen_resume row %0d got v=%b idx=%0d data=%h", r, m_valid, m_row_idx, m_data);
            end
            tick();
        end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL cen_captured got %b want 0", m_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL cen_overflow got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        m_ready = 1'b0; valid_in = 1'b1;
        result_in = mk_rc(); tick();
        result_in = fill(32'h0000_0055); tick();
        result_in = fill(32'h0000_0066); tick();
        valid_in = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        tests++; if (m_row_idx !== 3'd5 || overflow !== 1'b1) begin
            fails++; $display("FAIL rmid_setup got idx=%0d ovf=%b want idx=5 ovf=1", m_row_idx, overflow);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", m_valid); end
        tests++; if (m_row_idx !== 3'd0) begin fails++; $display("FAIL rmid_idx got %0d want 0", m_row_idx); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmid_overflow got %b want 0", overflow); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        for (int k = 0; k < 20; k++) begin
            if (m_valid !== 1'b0) stale++;
            tick();
        end
        tests++; if (stale !== 0) begin fails++; $display("FAIL rmid_stale got %0d beats want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_pingpong();
        test_overflow();
        test_cen();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mat_res_serializer.md
Name: mat_res_serializer

Overview:
- Downstream drain stage for the matrix-multiply unit.
- Captures each N×N signed W_OUT result matrix on the multiplier's valid_out pulse into a two-entry ping-pong buffer.
- Streams the matrix out one row per beat over a valid/ready interface toward the writeback/output path.
- Lets the multiplier issue back-to-back results while the consumer drains at its own pace; drops and flags results that arrive when both buffers are occupied.

Parameters:
- W_OUT, 32, width of one signed result element.
- N, 8, matrix dimension (rows and columns); power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- cen  in  1  clock enable; when low, all state holds.
- valid_in  in  1  single-cycle pulse from the multiplier's valid_out.
- result_in  in  N*N*W_OUT  packed signed [N-1:0][N-1:0][W_OUT-1:0], indexed [row][col].
- in_ready  out  1  high when at least one buffer is free; advisory, not a stall.
- m_valid  out  1  output row valid.
- m_ready  in  1  consumer accepts the row.
- m_data  out  N*W_OUT  one row; column c at bits [c*W_OUT +: W_OUT].
- m_row_idx  out  $clog2(N)  index of the row currently presented.
- m_last  out  1  presented row is row N-1.
- overflow  out  1  sticky flag: a result was dropped.

Behaviour:
- State:
  - buf[0:1] matrix registers.
  - full[1:0], wr_sel, rd_sel, row_cnt, overflow.
  - Buffer contents are not reset.
- Reset (rstn low at an edge, overrides cen):
  - full=0, wr_sel=0, rd_sel=0, row_cnt=0, overflow=0.
  - Outputs after reset: m_valid=0, m_data=0, m_last=0, m_row_idx=0, in_ready=1, overflow=0.
  - Reset mid-drain discards both buffers; no further beats are issued.
- Capture, on an edge with cen=1 and valid_in=1:
  - If full[wr_sel]=0: buf[wr_sel] ← result_in, full[wr_sel] ← 1, wr_sel toggles.
  - Else: the matrix is dropped, overflow ← 1 (sticky until reset), and no other state changes.
- in_ready = !full[wr_sel], from registered state only.
  - A buffer released on the same edge does not admit a capture on that edge. If both were full, that capture is dropped.
- Output path (combinational from registers):
  - m_valid = cen & full[rd_sel].
  - m_data = m_valid ? buf[rd_sel][row_cnt] : 0.
  - m_last = m_valid & (row_cnt == N-1).
  - m_row_idx = row_cnt.
- Transfer occurs on an edge with cen=1, m_valid=1 and m_ready=1:
  - If row_cnt < N-1: row_cnt increments.
  - If row_cnt == N-1: row_cnt ← 0, full[rd_sel] ← 0, rd_sel toggles.
- Latency:
  - Capture at edge T gives m_valid=1 in the cycle after T (row 0), provided the other buffer is empty.
  - Minimum drain is N cycles per matrix at m_ready=1.
- Ordering: matrices emerge in capture order; rows emerge 0..N-1.
- Simultaneous capture into wr_sel and last-row release of rd_sel on the same edge: both take effect. The next matrix starts at row 0 on the following cycle with no bubble.
- m_ready held high while m_valid=0 has no effect.
- m_data/m_row_idx must stay stable while m_valid=1 and m_ready=0.
- cen=0:
  - No capture (valid_in ignored, no overflow), no transfer.
  - m_valid forced low; row_cnt and buffers hold.
  - Draining resumes at the same row when cen returns high.
- Widths: pure data movement; no arithmetic on elements, sign bits preserved.

Test Plan:
- Reset then single matrix: load result_in with element[r][c] = r*16+c, pulse valid_in, m_ready=1. Required: m_valid high on the next cycle. 8 beats, m_row_idx 0..7, beat r carries column c = r*16+c. m_last only on beat 7; then m_valid=0 and in_ready=1.
- Backpressure: same load, m_ready toggles 1,0,0,1 repeating. Required: row held stable during low-ready cycles; exactly 8 transfers, in order, with no duplicates or skips.
- Ping-pong: matrices A (all -1) and B (all 0x7FFFFFFF) pulsed 2 cycles apart, m_ready=1. Required: 8 beats of -1 then 8 beats of 0x7FFFFFFF back-to-back with no bubble; overflow=0.
- Overflow: m_ready=0, pulse A, B, C. Required: in_ready=0 after B; C dropped and overflow=1. Release m_ready: only A then B are emitted, and overflow stays 1.
- cen gating: mid-drain at row 3 drop cen for 5 cycles and pulse valid_in during the gap. Required: m_valid=0 during the gap, no capture. Resumes at row 3; overflow unchanged.
- Reset mid-operation: both buffers full, assert rstn=0 for 1 cycle at row 5. Required: next cycle m_valid=0, m_row_idx=0, overflow=0, in_ready=1; no stale rows emitted afterward.
